layer4_stream_ctrl: RTL

// - Streaming access controller for the 144x128b dual-port layer4 SRAM wrapper.
// - Port A is write-only. It fills one frame sequentially from a valid/ready producer
//   (the conv/pool result path).
// - Port B is read-only. It streams the same frame, in order, to a valid/ready consumer
//   (the next layer). Reads may overlap the fill.
// - A prefetch FIFO hides the 1-cycle SRAM read latency.
// - The controller never drives A==B while both ports are active.

---
 rtl/layer4_stream_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/layer4_stream_ctrl.sv
// Streaming access controller for the layer4 dual-port SRAM: port A fills a frame
// from a producer, port B streams it out in order through a small prefetch FIFO.
module layer4_stream_ctrl #(
    parameter int DEPTH = 144,
    parameter int AW    = 8,
    parameter int DW    = 128,
    parameter int PF    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          frame_done,
    output logic [AW-1:0] wr_cnt,
    output logic [AW-1:0] sram_A,
    output logic          sram_WEAN,
    output logic          sram_OEA,
    output logic [DW-1:0] sram_DIA,
    output logic [AW-1:0] sram_B,
    output logic          sram_WEBN,
    output logic          sram_OEB,
    output logic [DW-1:0] sram_DIB,
    input  logic [DW-1:0] sram_DOB
);

    localparam int IW = (PF > 1) ? $clog2(PF) : 1;
    localparam int CW = $clog2(PF + 2);
    localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
    localparam logic [CW-1:0] PF_C     = CW'(PF);
    localparam logic [IW-1:0] LAST_IDX = IW'(PF - 1);

    logic [AW-1:0] wr_ptr, rd_iss, rd_cnt, b_addr;
    logic          inflight;
    logic [DW-1:0] fifo_mem [PF];
    logic [IW-1:0] head, tail;
    logic [CW-1:0] fifo_cnt, credit;
    logic          wr_fire, issue, push, pop;

    // Both sides use valid/ready: a word moves in a cycle where valid and ready are
    // both high; valid never depends on ready, and clr forces both readies/valids low.
    assign wr_ready   = (wr_ptr < DEPTH_A) & ~clr;
    assign wr_fire    = wr_valid & wr_ready;
    assign rd_valid   = (fifo_cnt != '0) & ~clr;
    assign pop        = rd_valid & rd_ready;
    assign rd_data    = fifo_mem[head];
    assign rd_last    = rd_valid & (rd_cnt == LAST_A);
    assign frame_done = pop & (rd_cnt == LAST_A);
    assign wr_cnt     = wr_ptr;

    // Credit counts the slot freed by this cycle's pop so the FIFO can stream at full rate.
    assign push   = inflight & ~clr;
    assign credit = fifo_cnt + CW'(inflight) - CW'(pop);
    assign issue  = ~clr & (rd_iss < wr_ptr) & (credit < PF_C);

    assign sram_A    = wr_ptr;
    assign sram_WEAN = ~wr_fire;
    assign sram_OEA  = 1'b0;
    assign sram_DIA  = wr_data;
    assign sram_B    = issue ? rd_iss : b_addr;
    assign sram_WEBN = 1'b1;
    assign sram_OEB  = issue;
    assign sram_DIB  = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_iss   <= '0;
            rd_cnt   <= '0;
            b_addr   <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            fifo_cnt <= '0;
        end else if (clr || frame_done) begin
            wr_ptr   <= '0;
            rd_iss   <= '0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            fifo_cnt <= '0;
            if (clr) b_addr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (issue) begin
                rd_iss <= rd_iss + 1'b1;
                b_addr <= rd_iss;
            end
            inflight <= issue;
            if (push) tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
            if (pop) begin
                head   <= (head == LAST_IDX) ? '0 : head + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // SRAM read data lands here one cycle after its issue.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail] <= sram_DOB;
    end

endmodule
